// File: rtl/set_eval_if.sv
// Job/coordinate bus between the SET controller, the coordinate generator and set_eval.
interface set_eval_if #(
    parameter int CNT_W = 7
);
    logic             en_i;
    logic [15:0]      central_i;
    logic [7:0]       radius_i;
    logic [1:0]       mode_i;
    logic             coord_en_o;
    logic [3:0]       start_row_o;
    logic [7:0]       coord_i;
    logic             coord_vld_i;
    logic             busy_o;
    logic             valid_o;
    logic [CNT_W-1:0] candidate_o;

    // set_eval side
    modport slave (
        input  en_i, central_i, radius_i, mode_i, coord_i, coord_vld_i,
        output coord_en_o, start_row_o, busy_o, valid_o, candidate_o
    );

    // controller / generator side
    modport master (
        output en_i, central_i, radius_i, mode_i, coord_i, coord_vld_i,
        input  coord_en_o, start_row_o, busy_o, valid_o, candidate_o
    );
endinterface

// File: rtl/set_eval.sv
// set_eval: tests each streamed grid point against two circles and counts
// the points that satisfy the selected set operation.
module set_eval #(
    parameter int         GRID_PTS  = 64,
    parameter logic [3:0] START_ROW = 4'd1,
    parameter int         CNT_W     = 7
) (
    input  logic      clk_i,
    input  logic      rst_i,
    set_eval_if.slave bus
);
    localparam int PW = $clog2(GRID_PTS) + 1;

    typedef enum logic [2:0] {IDLE, REQ, SCAN, DRAIN, DONE} state_t;

    state_t           r_state;
    logic [15:0]      r_central;
    logic [7:0]       r_radius;
    logic [1:0]       r_mode;
    logic [PW-1:0]    r_pts;
    logic             r_drain;
    logic             r_coord_en;
    logic             r_busy;
    logic             r_valid;
    logic [CNT_W-1:0] r_cand;
    logic             r_s1_vld;
    logic [8:0]       r_da;
    logic [8:0]       r_db;

    logic             w_accept;
    logic [3:0]       w_dxa, w_dya, w_dxb, w_dyb;
    logic [8:0]       w_da, w_db;
    logic [7:0]       w_ra2, w_rb2;
    logic             w_ina, w_inb, w_hit;

    function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [7:0] sq(input logic [3:0] d);
        return {4'b0, d} * {4'b0, d};
    endfunction

    assign w_accept = (r_state == SCAN) && bus.coord_vld_i;

    // Stage-1 distances: 4-bit absolute deltas, 8-bit squares, 9-bit sums.
    always_comb begin
        w_dxa = absdiff(bus.coord_i[7:4], r_central[15:12]);
        w_dya = absdiff(bus.coord_i[3:0], r_central[11:8]);
        w_dxb = absdiff(bus.coord_i[7:4], r_central[7:4]);
        w_dyb = absdiff(bus.coord_i[3:0], r_central[3:0]);
        w_da  = {1'b0, sq(w_dxa)} + {1'b0, sq(w_dya)};
        w_db  = {1'b0, sq(w_dxb)} + {1'b0, sq(w_dyb)};
    end

    // Stage-2 membership and set selection from the registered distances.
    always_comb begin
        w_ra2 = sq(r_radius[7:4]);
        w_rb2 = sq(r_radius[3:0]);
        w_ina = (r_da <= {1'b0, w_ra2});
        w_inb = (r_db <= {1'b0, w_rb2});
        case (r_mode)
            2'd0:    w_hit = w_ina;
            2'd1:    w_hit = w_inb;
            2'd2:    w_hit = w_ina & w_inb;
            default: w_hit = w_ina ^ w_inb;
        endcase
    end

    // Stage-1 register: capture distances of each accepted point.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_vld <= 1'b0;
            r_da     <= '0;
            r_db     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_da <= w_da;
                r_db <= w_db;
            end
        end
    end

    // Job FSM with registered strobes; the stage-2 count update lives here too.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_central  <= '0;
            r_radius   <= '0;
            r_mode     <= '0;
            r_pts      <= '0;
            r_drain    <= 1'b0;
            r_coord_en <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_cand     <= '0;
        end else begin
            r_coord_en <= 1'b0;
            r_valid    <= 1'b0;
            if (r_s1_vld && w_hit)
                r_cand <= r_cand + CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (bus.en_i) begin
                        r_central  <= bus.central_i;
                        r_radius   <= bus.radius_i;
                        r_mode     <= bus.mode_i;
                        r_cand     <= '0;
                        r_pts      <= '0;
                        r_coord_en <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: r_state <= SCAN;
                SCAN: begin
                    if (bus.coord_vld_i) begin
                        r_pts <= r_pts + PW'(1);
                        if (r_pts == PW'(GRID_PTS - 1)) begin
                            r_drain <= 1'b0;
                            r_state <= DRAIN;
                        end
                    end
                end
                // Two cycles so the final point clears both pipeline stages.
                DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.coord_en_o  = r_coord_en;
    assign bus.start_row_o = START_ROW;
    assign bus.busy_o      = r_busy;
    assign bus.valid_o     = r_valid;
    assign bus.candidate_o = r_cand;
endmodule

// File: tb/tb_set_eval.sv
// Bench for set_eval: plays the controller and coordinate generator, scores
// every beat against a geometric circle model.
module tb_set_eval;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    set_eval_if #(.CNT_W(7)) bus();

    set_eval #(.GRID_PTS(64), .START_ROW(4'd1), .CNT_W(7)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Point (x,y) inside circle = squared Euclidean distance <= r squared.
    function automatic int hit(input int x, input int y, input logic [15:0] c,
                               input logic [7:0] r, input logic [1:0] m);
        int xa = c[15:12];
        int ya = c[11:8];
        int xb = c[7:4];
        int yb = c[3:0];
        int ra = r[7:4];
        int rb = r[3:0];
        bit ia = ((x - xa) * (x - xa) + (y - ya) * (y - ya)) <= ra * ra;
        bit ib = ((x - xb) * (x - xb) + (y - yb) * (y - yb)) <= rb * rb;
        case (m)
            2'd0:    return int'(ia);
            2'd1:    return int'(ib);
            2'd2:    return int'(ia && ib);
            default: return int'(ia ^ ib);
        endcase
    endfunction

    // exp < 0 means use the model count; rst_after > 0 resets after that many beats.
    task automatic run_job(input string name, input logic [15:0] c, input logic [7:0] r,
                           input logic [1:0] m, input int gap, input bit rnd,
                           input bit poke, input int rst_after, input int exp);
        int idx = 0, n_en = 0, n_val = 0, last_cyc = -100, model = 0;
        int val_cyc = -1, rst_cyc = -1;
        bit gen = 1'b0;
        bus.central_i   = c;
        bus.radius_i    = r;
        bus.mode_i      = m;
        bus.en_i        = 1'b1;
        bus.coord_vld_i = 1'b1;   // stray beat in IDLE must be ignored
        bus.coord_i     = 8'h44;
        @(negedge clk);
        chk($sformatf("%s busy_on_accept", name), bus.busy_o, 1);
        for (int cyc = 1; cyc < 1000; cyc++) begin
            if (bus.coord_en_o) begin
                n_en++;
                chk($sformatf("%s start_row", name), bus.start_row_o, 1);
            end
            if (bus.valid_o) begin
                n_val++;
                if (val_cyc < 0) val_cyc = cyc;
            end
            if (val_cyc == cyc) begin
                chk($sformatf("%s busy_at_valid", name), bus.busy_o, 1);
                chk($sformatf("%s latency", name), cyc - last_cyc, 3);
                chk($sformatf("%s count", name), bus.candidate_o, (exp < 0) ? model : exp);
            end
            if (val_cyc >= 0 && cyc == val_cyc + 1)
                chk($sformatf("%s busy_after_valid", name), bus.busy_o, 0);
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                chk($sformatf("%s busy_after_rst", name), bus.busy_o, 0);
                chk($sformatf("%s count_after_rst", name), bus.candidate_o, 0);
            end
            if ((val_cyc >= 0 && cyc >= val_cyc + 3) || (rst_cyc >= 0 && cyc >= rst_cyc + 12))
                break;
            bus.en_i        = 1'b0;
            bus.coord_vld_i = 1'b0;
            bus.coord_i     = 8'($urandom);
            rst             = 1'b0;
            if (rst_after > 0 && idx == rst_after && rst_cyc < 0) begin
                rst     = 1'b1;
                rst_cyc = cyc;
                gen     = 1'b0;
            end else if (gen && idx < 64 && int'($urandom_range(99)) >= gap) begin
                int x, y;
                if (rnd) begin
                    x = int'($urandom_range(15));
                    y = int'($urandom_range(15));
                end else begin
                    x = 1 + idx % 8;
                    y = 1 + idx / 8;
                end
                bus.coord_i     = {x[3:0], y[3:0]};
                bus.coord_vld_i = 1'b1;
                model          += hit(x, y, c, r, m);
                idx++;
                last_cyc = cyc;
            end else if (!gen && bus.coord_en_o) begin
                bus.coord_vld_i = 1'b1;   // stray beat during REQ must be ignored
                bus.coord_i     = 8'h44;
            end
            if (poke && idx >= 10 && idx < 20) begin
                bus.en_i      = 1'b1;
                bus.central_i = ~c;
                bus.radius_i  = 8'hFF;
                bus.mode_i    = m + 2'd1;
            end
            if (bus.coord_en_o) gen = 1'b1;
            @(negedge clk);
        end
        rst             = 1'b0;
        bus.en_i        = 1'b0;
        bus.coord_vld_i = 1'b0;
        chk($sformatf("%s coord_en_cycles", name), n_en, 1);
        chk($sformatf("%s valid_strobes", name), n_val, (rst_after > 0) ? 0 : 1);
        @(negedge clk);
    endtask

    initial begin
        bus.en_i        = 1'b0;
        bus.central_i   = '0;
        bus.radius_i    = '0;
        bus.mode_i      = '0;
        bus.coord_i     = '0;
        bus.coord_vld_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", bus.busy_o, 0);
        chk("reset valid", bus.valid_o, 0);
        chk("reset count", bus.candidate_o, 0);
        chk("reset coord_en", bus.coord_en_o, 0);
        chk("reset start_row", bus.start_row_o, 1);

        run_job("m0",        16'h4411, 8'h20, 2'd0, 0,  1'b0, 1'b0, 0,  13);
        run_job("m1",        16'h4411, 8'h21, 2'd1, 0,  1'b0, 1'b0, 0,  3);
        run_job("m2",        16'h4444, 8'h20, 2'd2, 0,  1'b0, 1'b0, 0,  1);
        run_job("m3",        16'h4454, 8'h22, 2'd3, 0,  1'b0, 1'b0, 0,  10);
        run_job("full",      16'h4400, 8'hF0, 2'd0, 0,  1'b0, 1'b0, 0,  64);
        run_job("full_gaps", 16'h4400, 8'hF0, 2'd0, 30, 1'b0, 1'b0, 0,  64);
        run_job("m0_gaps",   16'h4411, 8'h20, 2'd0, 30, 1'b0, 1'b0, 0,  13);
        run_job("en_poke",   16'h4411, 8'h20, 2'd0, 10, 1'b0, 1'b1, 0,  13);
        run_job("rst_mid",   16'h4411, 8'h20, 2'd0, 0,  1'b0, 1'b0, 20, 0);
        run_job("post_rst",  16'h4411, 8'h20, 2'd0, 0,  1'b0, 1'b0, 0,  13);
        run_job("edge_ctr",  16'h0F9F, 8'h7C, 2'd3, 20, 1'b1, 1'b0, 0,  -1);
        run_job("r0_centre", 16'h3355, 8'h00, 2'd0, 0,  1'b0, 1'b0, 0,  1);
        for (int k = 0; k < 6; k++)
            run_job($sformatf("rand%0d", k), 16'($urandom), 8'($urandom),
                    2'($urandom), 30, 1'b1, 1'b0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
